rib_sram_slave: RTL

- RIB responder (slave) that terminates one RIB initiator port on an on-chip synchronous SRAM.
- Gives the SoC local scratch and boot memory that does not depend on the SDRAM path.
- Accepts the RIB request phase (addr/wrcs/mask/wdata/req/gnt) and returns exactly one in-order response per accepted request (rdata/rsp/rdy).
- Buffers responses so the initiator can stall rdy without losing data.

---
 rtl/rib_sram_slave_pkg.sv | 13 +
 rtl/rib_sram_bram.sv | 31 +++
 rtl/rib_sram_slave.sv | 114 +++++++++++
 3 files changed

// File: rtl/rib_sram_slave_pkg.sv
// Shared RIB bus definitions: widths and request-type encodings used by RIB endpoints.
package rib_sram_slave_pkg;
    localparam int RIB_AW = 32;
    localparam int RIB_DW = 32;
    localparam int RIB_MW = RIB_DW / 8;

    localparam logic WRCS_WRITE = 1'b1;
    localparam logic WRCS_READ  = 1'b0;

    typedef logic [RIB_AW-1:0] rib_addr_t;
    typedef logic [RIB_DW-1:0] rib_data_t;
    typedef logic [RIB_MW-1:0] rib_mask_t;
endpackage

// File: rtl/rib_sram_bram.sv
// Single-port synchronous RAM with byte write enables and 1-cycle read latency.
// No reset on the array or the read register so a vendor BRAM can drop in.
module rib_sram_bram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_en,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-masked write and registered read on every enabled cycle
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < DATA_WIDTH/8; b++) begin
                    if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/rib_sram_slave.sv
// RIB responder on a local SRAM: accepts requests while fewer than RSP_DEPTH are
// outstanding, accesses the RAM in the accept cycle and queues one in-order
// response per request so the initiator may stall rdy.
module rib_sram_slave
    import rib_sram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int RSP_DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [RIB_AW-1:0] i_ribs_addr,
    input  logic              i_ribs_wrcs,
    input  logic [RIB_MW-1:0] i_ribs_mask,
    input  logic [RIB_DW-1:0] i_ribs_wdata,
    input  logic              i_ribs_req,
    output logic              o_ribs_gnt,
    output logic [RIB_DW-1:0] o_ribs_rdata,
    output logic              o_ribs_rsp,
    input  logic              i_ribs_rdy
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] r_outstanding;
    logic             r_pend_vld;
    logic             r_pend_wr;
    rib_data_t        r_fifo [0:RSP_DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_pop;
    logic             w_is_wr;
    rib_data_t        w_ram_rdata;
    rib_data_t        w_push_data;
    logic             w_unused;

    // Only the word index selects a RAM location; the rest of the address aliases
    assign w_unused = ^{i_ribs_addr[RIB_AW-1:ADDR_WIDTH+2], i_ribs_addr[1:0]};

    // gnt is a function of the registered count only, so no req/rdy path to it
    assign o_ribs_gnt = (r_outstanding < CNT_W'(RSP_DEPTH));
    assign w_accept   = i_ribs_req & o_ribs_gnt;
    assign w_pop      = o_ribs_rsp & i_ribs_rdy;
    assign w_is_wr    = (i_ribs_wrcs == WRCS_WRITE);

    rib_sram_bram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (RIB_DW)
    ) u_bram (
        .i_clk   (i_clk),
        .i_en    (w_accept),
        .i_we    (w_is_wr),
        .i_be    (i_ribs_mask),
        .i_addr  (i_ribs_addr[ADDR_WIDTH+1:2]),
        .i_wdata (i_ribs_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Outstanding requests: +1 on accept, -1 on response handshake
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Tag pipeline: marks that RAM output next cycle belongs to an accepted request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_vld <= 1'b0;
            r_pend_wr  <= 1'b0;
        end else begin
            r_pend_vld <= w_accept;
            r_pend_wr  <= w_accept & w_is_wr;
        end
    end

    // Writes respond with zero; reads with the RAM output
    assign w_push_data = r_pend_wr ? '0 : w_ram_rdata;

    // Response FIFO storage; contents are don't-care while the slot is empty
    always_ff @(posedge i_clk) begin
        if (r_pend_vld) r_fifo[r_wr_ptr] <= w_push_data;
    end

    // FIFO pointers and occupancy; outstanding bound keeps it from overflowing
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_pend_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({r_pend_vld, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_ribs_rsp   = (r_count != '0);
    // Force zero while empty so rdata has a defined value out of reset
    assign o_ribs_rdata = o_ribs_rsp ? r_fifo[r_rd_ptr] : '0;
endmodule
